// File: rtl/analogue_decimation_ctrl_pkg.sv
// Shared definitions for the decimation scheduler: FSM encoding and default sizing.
package analogue_decimation_ctrl_pkg;

  localparam int STAGES_MAX     = 4;
  localparam int RATE_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/analogue_decimation_ctrl_valid_delay_line.sv
// Fixed-depth valid shift register with synchronous clear; carries y_valid to the output.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH:1] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= d;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH];

endmodule

// File: rtl/analogue_decimation_ctrl.sv
// Rate config, flush/settle sequencing and per-stage clock-enable generation for the
// decimate-by-2 cascade.
module analogue_decimation_ctrl
  import analogue_decimation_ctrl_pkg::*;
#(
  parameter int STAGES       = STAGES_MAX,
  parameter int RATE_WIDTH   = RATE_WIDTH_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int SETTLE       = 8,
  parameter int OUT_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic                  sample_in_valid,
  output logic [STAGES-1:0]     stage_ce,
  output logic                  stage_rst,
  output logic [RATE_WIDTH-1:0] tap_sel,
  output logic                  y_valid,
  output logic                  busy
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t                state, state_nxt;
  logic [RATE_WIDTH-1:0] rate;
  logic [STAGES-1:0]     cnt;
  logic [FW-1:0]         flush_cnt;
  logic [SW-1:0]         settle_cnt;
  logic [STAGES:0]       ones;
  logic [STAGES-1:0]     ce_d;
  logic                  act, ev, ev_q;
  logic                  cfg_acc, cfg_ok, cfg_take;
  logic                  flush_done, settle_done, pipe_clr;

  assign cfg_ready   = (state != ST_FLUSH);
  assign busy        = (state == ST_FLUSH) || (state == ST_SETTLE);
  assign tap_sel     = rate;
  assign act         = (state == ST_SETTLE) || (state == ST_RUN);
  assign cfg_acc     = cfg_valid & cfg_ready;
  assign cfg_ok      = (cfg_rate <= RATE_WIDTH'(STAGES));
  assign cfg_take    = cfg_acc & cfg_ok;
  assign flush_done  = (flush_cnt == FW'(FLUSH_CYCLES - 1));
  assign settle_done = (settle_cnt == SW'(SETTLE - 1));

  // ones[k]: low k phase bits all set, i.e. this sample completes a 2^k group.
  always_comb begin
    ones = '0;
    ce_d = '0;
    for (int k = 0; k <= STAGES; k++)
      ones[k] = &(cnt | ~STAGES'((1 << k) - 1));
    // Stage 0 always runs so rate 0 still clocks the first filter as a pass-through.
    for (int k = 0; k < STAGES; k++)
      ce_d[k] = act & sample_in_valid & ones[k] & ((k == 0) || (RATE_WIDTH'(k) < rate));
  end

  assign ev = act & sample_in_valid & ones[rate];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (flush_done) state_nxt = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
      ST_SETTLE: begin
        if (cfg_take)               state_nxt = ST_FLUSH;
        else if (ev && settle_done) state_nxt = ST_RUN;
      end
      ST_RUN:    if (cfg_take) state_nxt = ST_FLUSH;
      default:   state_nxt = ST_IDLE;
    endcase
    if (!run) state_nxt = ST_IDLE;
  end

  assign pipe_clr = (state_nxt == ST_FLUSH) || (state_nxt == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate       <= '0;
      cnt        <= '0;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      stage_ce   <= '0;
      stage_rst  <= 1'b0;
      cfg_err    <= 1'b0;
      ev_q       <= 1'b0;
    end else begin
      if (cfg_take) rate <= cfg_rate;
      cfg_err   <= cfg_acc & ~cfg_ok;
      stage_rst <= (state == ST_FLUSH);
      stage_ce  <= ce_d;
      // Settle-phase events are filter warm-up and never reach the capture buffer.
      ev_q      <= ev & (state == ST_RUN) & ~pipe_clr;
      if (state == ST_FLUSH)             cnt <= '0;
      else if (act && sample_in_valid)   cnt <= cnt + 1'b1;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
      if (state != ST_SETTLE) settle_cnt <= '0;
      else if (ev)            settle_cnt <= settle_cnt + 1'b1;
    end
  end

  valid_delay_line #(.DEPTH(OUT_LAT)) u_vdl (
    .clk (clk),
    .rst (rst),
    .clr (pipe_clr),
    .d   (ev_q),
    .q   (y_valid)
  );

endmodule
